// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipelined MIPS control unit: opcodes, control bundle
// layout and the bubble value.
package pipe_ctrl_pkg;

   localparam int unsigned OPCODE_W = 6;
   localparam int unsigned CTRL_W   = 10;

   // Opcodes
   localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
   localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
   localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
   localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
   localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;

   // Control bundle bit positions, MSB to LSB
   localparam int unsigned BIT_BRANCH_EQ  = 9;
   localparam int unsigned BIT_BRANCH_NE  = 8;
   localparam int unsigned BIT_ALU_OP_HI  = 7;
   localparam int unsigned BIT_ALU_OP_LO  = 6;
   localparam int unsigned BIT_ALU_SRC    = 5;
   localparam int unsigned BIT_REG_DST    = 4;
   localparam int unsigned BIT_MEM_READ   = 3;
   localparam int unsigned BIT_MEM_WRITE  = 2;
   localparam int unsigned BIT_MEM_TO_REG = 1;
   localparam int unsigned BIT_REG_WRITE  = 0;

   localparam logic [CTRL_W-1:0] BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control bundle, jump, illegal flag and whether
// rt is read as a source operand.
// Optional feature macro: PIPE_CTRL_IMM_LOGIC_EN (adds ANDI/ORI decode).
module ctrl_decode
   import pipe_ctrl_pkg::*;
(
   input  logic [OPCODE_W-1:0] opcode,
   output logic [CTRL_W-1:0]   ctrl,
   output logic                jump,
   output logic                illegal,
   output logic                rtIsSource
);

   // Opcode to control bundle; unknown opcodes produce a bubble and flag illegal
   always_comb begin
      ctrl       = BUBBLE;
      jump       = 1'b0;
      illegal    = 1'b0;
      rtIsSource = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            ctrl[BIT_REG_WRITE]               = 1'b1;
            ctrl[BIT_REG_DST]                 = 1'b1;
            ctrl[BIT_ALU_OP_HI:BIT_ALU_OP_LO] = 2'b10;
            rtIsSource                        = 1'b1;
         end
         OP_J: begin
            jump = 1'b1;
         end
         OP_BEQ: begin
            ctrl[BIT_ALU_OP_HI:BIT_ALU_OP_LO] = 2'b01;
            ctrl[BIT_BRANCH_EQ]               = 1'b1;
            rtIsSource                        = 1'b1;
         end
         OP_BNE: begin
            ctrl[BIT_ALU_OP_HI:BIT_ALU_OP_LO] = 2'b01;
            ctrl[BIT_BRANCH_NE]               = 1'b1;
            rtIsSource                        = 1'b1;
         end
         OP_ADDI: begin
            ctrl[BIT_ALU_SRC]   = 1'b1;
            ctrl[BIT_REG_WRITE] = 1'b1;
         end
         OP_LW: begin
            ctrl[BIT_MEM_READ]   = 1'b1;
            ctrl[BIT_MEM_TO_REG] = 1'b1;
            ctrl[BIT_ALU_SRC]    = 1'b1;
            ctrl[BIT_REG_WRITE]  = 1'b1;
         end
         OP_SW: begin
            ctrl[BIT_MEM_WRITE] = 1'b1;
            ctrl[BIT_ALU_SRC]   = 1'b1;
            rtIsSource          = 1'b1;
         end
`ifdef PIPE_CTRL_IMM_LOGIC_EN
         OP_ANDI, OP_ORI: begin
            ctrl[BIT_ALU_SRC]                 = 1'b1;
            ctrl[BIT_REG_WRITE]               = 1'b1;
            ctrl[BIT_ALU_OP_HI:BIT_ALU_OP_LO] = 2'b11;
         end
`else
         OP_ANDI, OP_ORI: begin
            illegal = 1'b1;
         end
`endif
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipelined MIPS control unit: decodes the IF/ID opcode, carries the control
// bundle through ID/EX, EX/MEM and MEM/WB, resolves load-use hazards with a
// one-cycle stall plus bubble, applies branch flushes and counts illegal opcodes.
// Optional feature macro: PIPE_CTRL_IMM_LOGIC_EN (handled in ctrl_decode).
module pipeline_control_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned ILL_CNT_W  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [OPCODE_W-1:0]   opcode,
   input  logic                  idValid,
   input  logic [REG_ADDR_W-1:0] ifidRs,
   input  logic [REG_ADDR_W-1:0] ifidRt,
   input  logic                  flush,
   output logic                  stall,
   output logic                  idJump,
   output logic [CTRL_W-1:0]     exCtrl,
   output logic [CTRL_W-1:0]     memCtrl,
   output logic [CTRL_W-1:0]     wbCtrl,
   output logic [REG_ADDR_W-1:0] exRt,
   output logic                  illegalOp,
   output logic [ILL_CNT_W-1:0]  illegalCount
);

   logic [CTRL_W-1:0] decCtrl;
   logic              decJump;
   logic              decIllegal;
   logic              decRtIsSource;
   logic              idLive;
   logic              loadId;
   logic              illegalEvent;

   ctrl_decode u_ctrl_decode (
      .opcode     (opcode),
      .ctrl       (decCtrl),
      .jump       (decJump),
      .illegal    (decIllegal),
      .rtIsSource (decRtIsSource)
   );

   // Hazard detection, jump and ID/EX load qualification
   always_comb begin
      idLive       = idValid & ~flush;
      // Register 0 is not special-cased; a spurious stall on it is harmless
      stall        = ~reset & idLive & exCtrl[BIT_MEM_READ] &
                     ((exRt == ifidRs) | (decRtIsSource & (exRt == ifidRt)));
      idJump       = idLive & decJump;
      loadId       = idLive & ~stall;
      illegalEvent = idLive & decIllegal;
   end

   // Stage registers and saturating illegal-opcode counter
   always_ff @(posedge clk) begin
      if (reset) begin
         exCtrl       <= BUBBLE;
         memCtrl      <= BUBBLE;
         wbCtrl       <= BUBBLE;
         exRt         <= '0;
         illegalOp    <= 1'b0;
         illegalCount <= '0;
      end else begin
         exCtrl  <= loadId ? decCtrl : BUBBLE;
         if (loadId) begin
            exRt <= ifidRt;
         end
         // Later stages never stall; a flush only kills the ID instruction
         memCtrl   <= exCtrl;
         wbCtrl    <= memCtrl;
         illegalOp <= illegalEvent;
         if (illegalEvent && (illegalCount != {ILL_CNT_W{1'b1}})) begin
            illegalCount <= illegalCount + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed self-checking bench for pipeline_control_unit (ILL_CNT_W=2 so that
// counter saturation is reachable quickly).
module tb_pipeline_control_unit;

   localparam int unsigned RW = 5;
   localparam int unsigned CW = 2;

   localparam logic [9:0] C_RTYPE = 10'h091;
   localparam logic [9:0] C_BEQ   = 10'h240;
   localparam logic [9:0] C_ADDI  = 10'h021;
   localparam logic [9:0] C_LW    = 10'h02B;
   localparam logic [9:0] C_SW    = 10'h024;

`ifdef PIPE_CTRL_IMM_LOGIC_EN
   localparam logic [9:0] C_IMM   = 10'h0E1;
   localparam logic       IMM_ILL = 1'b0;
`else
   localparam logic [9:0] C_IMM   = 10'h000;
   localparam logic       IMM_ILL = 1'b1;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [5:0]    opcode;
   logic          idValid;
   logic [RW-1:0] ifidRs;
   logic [RW-1:0] ifidRt;
   logic          flush;
   logic          stall;
   logic          idJump;
   logic [9:0]    exCtrl;
   logic [9:0]    memCtrl;
   logic [9:0]    wbCtrl;
   logic [RW-1:0] exRt;
   logic          illegalOp;
   logic [CW-1:0] illegalCount;

   int checks = 0;
   int fails  = 0;

   pipeline_control_unit #(
      .REG_ADDR_W (RW),
      .ILL_CNT_W  (CW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .opcode       (opcode),
      .idValid      (idValid),
      .ifidRs       (ifidRs),
      .ifidRt       (ifidRt),
      .flush        (flush),
      .stall        (stall),
      .idJump       (idJump),
      .exCtrl       (exCtrl),
      .memCtrl      (memCtrl),
      .wbCtrl       (wbCtrl),
      .exRt         (exRt),
      .illegalOp    (illegalOp),
      .illegalCount (illegalCount)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [5:0] op, input logic [RW-1:0] rs, input logic [RW-1:0] rt);
      opcode  = op;
      ifidRs  = rs;
      ifidRt  = rt;
      idValid = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b1; idValid = 1'b0; flush = 1'b0;
      opcode = 6'b0; ifidRs = '0; ifidRt = '0;
      tick();
      tick();
      checks++; if (exCtrl !== 10'h000) begin fails++; $display("FAIL reset_ex: got %h want %h", exCtrl, 10'h000); end
      checks++; if (memCtrl !== 10'h000) begin fails++; $display("FAIL reset_mem: got %h want %h", memCtrl, 10'h000); end
      checks++; if (wbCtrl !== 10'h000) begin fails++; $display("FAIL reset_wb: got %h want %h", wbCtrl, 10'h000); end
      checks++; if (exRt !== 5'd0) begin fails++; $display("FAIL reset_exrt: got %0d want 0", exRt); end
      checks++; if (illegalOp !== 1'b0) begin fails++; $display("FAIL reset_illop: got %b want 0", illegalOp); end
      checks++; if (illegalCount !== 2'd0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", illegalCount); end
      checks++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall); end
      reset = 1'b0;
   endtask

   task automatic test_latency;
      issue(6'b100011, 5'd1, 5'd5);
      tick();
      idValid = 1'b0;
      checks++; if (exCtrl !== C_LW) begin fails++; $display("FAIL lat_ex: got %h want %h", exCtrl, C_LW); end
      checks++; if (exRt !== 5'd5) begin fails++; $display("FAIL lat_exrt: got %0d want 5", exRt); end
      tick();
      checks++; if (memCtrl !== C_LW) begin fails++; $display("FAIL lat_mem: got %h want %h", memCtrl, C_LW); end
      checks++; if (exCtrl !== 10'h000) begin fails++; $display("FAIL lat_ex_bubble: got %h want %h", exCtrl, 10'h000); end
      tick();
      checks++; if (wbCtrl !== C_LW) begin fails++; $display("FAIL lat_wb: got %h want %h", wbCtrl, C_LW); end
   endtask

   task automatic test_load_use;
      // LW r5 then R-type reading r5 through rs
      issue(6'b100011, 5'd1, 5'd5);
      tick();
      issue(6'b000000, 5'd5, 5'd2);
      #1;
      checks++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_stall: got %b want 1", stall); end
      tick();
      checks++; if (exCtrl !== 10'h000) begin fails++; $display("FAIL lu_bubble: got %h want %h", exCtrl, 10'h000); end
      checks++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_stall_drop: got %b want 0", stall); end
      tick();
      checks++; if (exCtrl !== C_RTYPE) begin fails++; $display("FAIL lu_resume: got %h want %h", exCtrl, C_RTYPE); end
      // Independent registers: no stall
      issue(6'b100011, 5'd1, 5'd5);
      tick();
      issue(6'b000000, 5'd6, 5'd7);
      #1;
      checks++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_nostall: got %b want 0", stall); end
      tick();
      checks++; if (exCtrl !== C_RTYPE) begin fails++; $display("FAIL lu_nostall_ex: got %h want %h", exCtrl, C_RTYPE); end
      // SW reads rt as a source
      issue(6'b100011, 5'd1, 5'd5);
      tick();
      issue(6'b101011, 5'd1, 5'd5);
      #1;
      checks++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_sw_rt: got %b want 1", stall); end
      tick();
      idValid = 1'b0;
      checks++; if (exCtrl !== 10'h000) begin fails++; $display("FAIL lu_sw_bubble: got %h want %h", exCtrl, 10'h000); end
      // ADDI does not read rt
      issue(6'b100011, 5'd1, 5'd5);
      tick();
      issue(6'b001000, 5'd1, 5'd5);
      #1;
      checks++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_addi_rt: got %b want 0", stall); end
      tick();
      idValid = 1'b0;
      checks++; if (exCtrl !== C_ADDI) begin fails++; $display("FAIL lu_addi_ex: got %h want %h", exCtrl, C_ADDI); end
   endtask

   task automatic test_flush;
      issue(6'b100011, 5'd1, 5'd5);
      tick();
      issue(6'b000000, 5'd5, 5'd2);
      flush = 1'b1;
      #1;
      checks++; if (stall !== 1'b0) begin fails++; $display("FAIL fl_stall: got %b want 0", stall); end
      tick();
      checks++; if (exCtrl !== 10'h000) begin fails++; $display("FAIL fl_ex: got %h want %h", exCtrl, 10'h000); end
      // BEQ in EX while the instruction behind it is flushed
      flush = 1'b0;
      issue(6'b000100, 5'd3, 5'd4);
      tick();
      issue(6'b001000, 5'd1, 5'd9);
      flush = 1'b1;
      tick();
      flush = 1'b0; idValid = 1'b0;
      checks++; if (memCtrl !== C_BEQ) begin fails++; $display("FAIL fl_beq_mem: got %h want %h", memCtrl, C_BEQ); end
      checks++; if (exCtrl !== 10'h000) begin fails++; $display("FAIL fl_killed: got %h want %h", exCtrl, 10'h000); end
   endtask

   task automatic test_jump;
      issue(6'b000010, 5'd0, 5'd0);
      #1;
      checks++; if (idJump !== 1'b1) begin fails++; $display("FAIL j_taken: got %b want 1", idJump); end
      flush = 1'b1;
      #1;
      checks++; if (idJump !== 1'b0) begin fails++; $display("FAIL j_flushed: got %b want 0", idJump); end
      flush = 1'b0;
      tick();
      idValid = 1'b0;
      checks++; if (exCtrl !== 10'h000) begin fails++; $display("FAIL j_bundle: got %h want %h", exCtrl, 10'h000); end
      checks++; if (illegalOp !== 1'b0) begin fails++; $display("FAIL j_illop: got %b want 0", illegalOp); end
   endtask

   task automatic test_illegal;
      logic [CW-1:0] expCnt [5];
      expCnt[0] = 2'd1; expCnt[1] = 2'd2; expCnt[2] = 2'd3; expCnt[3] = 2'd3; expCnt[4] = 2'd3;
      // A flushed illegal opcode is not counted
      issue(6'b111111, 5'd0, 5'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (illegalOp !== 1'b0) begin fails++; $display("FAIL ill_flush_pulse: got %b want 0", illegalOp); end
      checks++; if (illegalCount !== 2'd0) begin fails++; $display("FAIL ill_flush_cnt: got %0d want 0", illegalCount); end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (illegalOp !== 1'b1) begin fails++; $display("FAIL ill_pulse[%0d]: got %b want 1", i, illegalOp); end
         checks++; if (illegalCount !== expCnt[i]) begin fails++; $display("FAIL ill_cnt[%0d]: got %0d want %0d", i, illegalCount, expCnt[i]); end
         checks++; if (exCtrl !== 10'h000) begin fails++; $display("FAIL ill_bundle[%0d]: got %h want %h", i, exCtrl, 10'h000); end
      end
      idValid = 1'b0;
      tick();
      checks++; if (illegalOp !== 1'b0) begin fails++; $display("FAIL ill_pulse_end: got %b want 0", illegalOp); end
      checks++; if (illegalCount !== 2'd3) begin fails++; $display("FAIL ill_cnt_hold: got %0d want 3", illegalCount); end
   endtask

   task automatic test_mid_reset;
      issue(6'b100011, 5'd1, 5'd3);
      tick();
      issue(6'b101011, 5'd4, 5'd8);
      tick();
      issue(6'b100011, 5'd2, 5'd9);
      tick();
      checks++; if (wbCtrl !== C_LW) begin fails++; $display("FAIL mr_pre_wb: got %h want %h", wbCtrl, C_LW); end
      checks++; if (memCtrl !== C_SW) begin fails++; $display("FAIL mr_pre_mem: got %h want %h", memCtrl, C_SW); end
      reset = 1'b1;
      issue(6'b000000, 5'd9, 5'd1);
      #1;
      checks++; if (stall !== 1'b0) begin fails++; $display("FAIL mr_stall_held: got %b want 0", stall); end
      tick();
      checks++; if (exCtrl !== 10'h000) begin fails++; $display("FAIL mr_ex: got %h want %h", exCtrl, 10'h000); end
      checks++; if (memCtrl !== 10'h000) begin fails++; $display("FAIL mr_mem: got %h want %h", memCtrl, 10'h000); end
      checks++; if (wbCtrl !== 10'h000) begin fails++; $display("FAIL mr_wb: got %h want %h", wbCtrl, 10'h000); end
      checks++; if (exRt !== 5'd0) begin fails++; $display("FAIL mr_exrt: got %0d want 0", exRt); end
      checks++; if (illegalCount !== 2'd0) begin fails++; $display("FAIL mr_cnt: got %0d want 0", illegalCount); end
      reset = 1'b0; idValid = 1'b0;
   endtask

   task automatic test_imm_logic;
      issue(6'b001100, 5'd1, 5'd2);
      tick();
      checks++; if (exCtrl !== C_IMM) begin fails++; $display("FAIL andi_ex: got %h want %h", exCtrl, C_IMM); end
      checks++; if (illegalOp !== IMM_ILL) begin fails++; $display("FAIL andi_illop: got %b want %b", illegalOp, IMM_ILL); end
      issue(6'b001101, 5'd1, 5'd2);
      tick();
      idValid = 1'b0;
      checks++; if (exCtrl !== C_IMM) begin fails++; $display("FAIL ori_ex: got %h want %h", exCtrl, C_IMM); end
      checks++; if (illegalCount !== {1'b0, IMM_ILL} + {1'b0, IMM_ILL}) begin
         fails++; $display("FAIL imm_cnt: got %0d want %0d", illegalCount, {1'b0, IMM_ILL} + {1'b0, IMM_ILL});
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_load_use();
      test_flush();
      test_jump();
      test_illegal();
      test_mid_reset();
      test_imm_logic();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/pipeline_control_unit.md
# pipeline_control_unit

Pipelined successor to the single-cycle MIPS control decoder. It decodes the opcode held in IF/ID and produces the control bundle for that instruction. It carries the bundle through ID/EX, EX/MEM and MEM/WB registers and detects load-use hazards, which it handles by raising a stall and inserting a bubble. It also applies branch flushes and counts illegal opcodes. It sits between the IF/ID register and the datapath stage registers in the 5-stage core.

## Interface
Parameters:
- `REG_ADDR_W`, default 5: width of the register specifier.
- `ILL_CNT_W`, default 8: width of the saturating illegal-opcode counter.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `opcode`  in  6  opcode of the instruction in IF/ID.
- `idValid`  in  1  IF/ID holds a real instruction.
- `ifidRs`  in  REG_ADDR_W  rs field of the IF/ID instruction.
- `ifidRt`  in  REG_ADDR_W  rt field of the IF/ID instruction.
- `flush`  in  1  branch taken in EX; kill the instruction in ID this cycle.
- `stall`  out  1  combinational; freeze the PC and IF/ID.
- `idJump`  out  1  combinational; jump taken in ID.
- `exCtrl`  out  CTRL_W  ID/EX control bundle.
- `memCtrl`  out  CTRL_W  EX/MEM control bundle.
- `wbCtrl`  out  CTRL_W  MEM/WB control bundle.
- `exRt`  out  REG_ADDR_W  registered rt of the ID/EX instruction.
- `illegalOp`  out  1  registered one-cycle pulse; an illegal opcode was decoded.
- `illegalCount`  out  ILL_CNT_W  saturating count of illegal opcodes.

## Operation
- CTRL_W = 10. Bundle bit layout, MSB to LSB:
  - branchEqual[9], branchNotEqual[8], ALU_op[7:6], ALU_source[5]
  - regDst[4], memRead[3], memWrite[2], memToReg[1], regWrite[0]
- Bubble = all zeros.
- Decode (bundle value in hex):
  - R-type 000000: regWrite, regDst, ALU_op=10 → 0x091.
  - J 000010: idJump=1, bundle = bubble.
  - BEQ 000100: ALU_op=01, branchEqual → 0x240.
  - BNE 000101: ALU_op=01, branchNotEqual → 0x140.
  - ADDI 001000: ALU_source, regWrite, ALU_op=00 → 0x021.
  - LW 100011: memRead, memToReg, ALU_source, regWrite → 0x02B.
  - SW 101011: memWrite, ALU_source → 0x024.
  - Any other opcode: illegal; bundle = bubble.
- rt is a source operand for R-type, BEQ, BNE and SW only.
- stall = idValid & !flush & exCtrl.memRead & (exRt==ifidRs | (rtIsSource & exRt==ifidRt)).
  - No special case for register 0; a stall on it is harmless.
- ID/EX load rule:
  - Bubble if reset, flush, stall or !idValid.
  - Otherwise the decoded bundle, and exRt ← ifidRt.
- exRt updates whenever ID/EX loads a non-bubble instruction.
- EX/MEM and MEM/WB never stall: memCtrl ← exCtrl and wbCtrl ← memCtrl every cycle.
- idJump = idValid & !flush & (opcode==J).
- Illegal handling:
  - illegalOp asserts the cycle after idValid & !flush & illegal opcode.
  - illegalCount increments at the same edge and saturates at all-ones.

## Timing
- Instruction decoded in cycle N: exCtrl valid in N+1, memCtrl in N+2, wbCtrl in N+3.
- stall and idJump are combinational in the same cycle as their inputs.
- Load-use costs exactly one bubble. The cycle after the stall, exCtrl.memRead is 0 for that bubble, so stall drops.
- flush with stall in the same cycle: flush wins, stall=0, ID/EX loads a bubble.
- flush does not affect EX/MEM or MEM/WB. The branch in EX completes normally.
- Reset values (applied at the next edge, including mid-pipeline):
  - exCtrl, memCtrl, wbCtrl = 0, exRt = 0.
  - illegalOp = 0, illegalCount = 0.
- While reset is held, stall = 0.

## Configuration
- Macro `PIPE_CTRL_IMM_LOGIC_EN`.
- Defined: ANDI 001100 and ORI 001101 decode to ALU_source, regWrite, ALU_op=11 → 0x0E1. rt is not a source for these.
- Undefined: both opcodes are illegal (bubble, illegalOp pulse, count increment).

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - Opcode constants.
  - CTRL_W and the bit-position constants for each bundle field.
  - The BUBBLE constant.
- Natural sub-module: `ctrl_decode`, combinational. Maps opcode to bundle, jump, illegal and rtIsSource.
- Hazard logic, stage registers and the counter live in the top module.

## Test plan
- Single-instruction latency:
  - LW (100011), idValid=1 for one cycle → exCtrl=0x02B next cycle, memCtrl=0x02B the cycle after, then wbCtrl=0x02B.
- Load-use:
  - LW rt=5, then R-type with rs=5 → stall=1 for exactly one cycle, exCtrl=0 for that cycle, then 0x091.
  - R-type with rs=6, rt=7 → no stall.
- Flush priority:
  - Load-use condition plus flush=1 → stall=0, exCtrl=0.
  - BEQ in memCtrl still 0x240.
- Illegal saturation:
  - ILL_CNT_W=2, opcode 111111 × 5 → illegalOp pulses 5 times, illegalCount stops at 3.
- Mid-stream reset:
  - Pipeline full of LW/SW, reset=1 for one edge → all bundles 0 and counter 0 after that edge.
- Macro:
  - ANDI 001100 → exCtrl=0x0E1 with `PIPE_CTRL_IMM_LOGIC_EN` defined.
  - Without the macro → exCtrl=0 and an illegalOp pulse.
